vga_draw_image: RTL and testbench
=================================

// Module: vga_draw_image
// PURPOSE
//  Reader side of the image-ROM interface. Takes the VGA timing stream and a requested
//  top-left position (xpos, ypos). Issues per-pixel ROM addresses and overlays the returned
//  12-bit image pixel onto the background rgb. Sits between the background/timing stage and
//  the final VGA output register, next to the 64K x 12 image ROM (registered read).
// PARAMETERS
//  IMG_WIDTH    200      image width in pixels (<=256)
//  IMG_HEIGHT   100      image height in pixels (<=256)
//  ROM_LATENCY  1        clocks from address to rgb_pixel valid (registered ROM read)
//  TRANSP_EN    0        1: pixels equal to TRANSP_RGB show background instead
//  TRANSP_RGB   12'hF0F  colour key used when TRANSP_EN=1
// PORTS
//  clk        in   1   pixel clock
//  rst        in   1   synchronous, active-high reset
//  hcount_in  in   11  horizontal pixel counter
//  vcount_in  in   11  vertical line counter
//  hsync_in   in   1   horizontal sync
//  vsync_in   in   1   vertical sync
//  hblnk_in   in   1   horizontal blanking
//  vblnk_in   in   1   vertical blanking
//  rgb_in     in   12  background colour {r,g,b}
//  xpos       in   12  requested image left edge, screen coordinates
//  ypos       in   12  requested image top edge, screen coordinates
//  address    out  16  ROM address = {rel_y[7:0], rel_x[7:0]}
//  rgb_pixel  in   12  ROM data, valid ROM_LATENCY clocks after address
//  hcount_out out  11  hcount_in delayed by LATENCY
//  vcount_out out  11  vcount_in delayed by LATENCY
//  hsync_out  out  1   delayed hsync; hblnk/vblnk/vsync likewise
//  vsync_out  out  1
//  hblnk_out  out  1
//  vblnk_out  out  1
//  rgb_out    out  12  composited colour
// BEHAVIOUR
//  - LATENCY = ROM_LATENCY + 2; every *_out is its *_in delayed exactly LATENCY clocks.
//  - Position latch: xpos/ypos are sampled into xpos_q/ypos_q only on the first clock of
//    vblnk_in (vblnk_in=1, previous vblnk_in=0); constant for the whole visible frame.
//    Changing xpos/ypos mid-frame never tears the image.
//  - Stage 1 (registered): rel_x = hcount_in - xpos_q, rel_y = vcount_in - ypos_q, 12-bit.
//    in_win = (hcount_in>=xpos_q) && (hcount_in<xpos_q+IMG_WIDTH) && same for v. Compares
//    use 13-bit sums, so no wrap. address <= in_win ? {rel_y[7:0],rel_x[7:0]} : 16'h0.
//  - in_win and background/timing travel in a delay line of ROM_LATENCY+1 stages.
//  - Output stage (registered), in priority:
//    blank (hblnk|vblnk delayed) -> rgb_out=0;
//    in_win_d && !(TRANSP_EN && rgb_pixel==TRANSP_RGB) -> rgb_out=rgb_pixel;
//    else rgb_out = rgb_in delayed.
//  - Clipping: image partly off-screen (e.g. xpos=1000) shows only the on-screen part, no
//    wrap to the left edge. xpos >= 4096-IMG_WIDTH cannot wrap (13-bit compare).
//  - Reset: all outputs, address, xpos_q, ypos_q and every pipeline stage go to 0.
//    After rst falls mid-frame, outputs stay 0 for LATENCY clocks, then track the inputs.
//    The image uses position 0,0 until the next vblnk edge.
// STRUCTURE
//  - Shared VGA package/header holds count widths (11), RGB width (12), ROM address width
//    (16) and the blank colour 12'h000.
//  - One sub-module: signal_delay (WIDTH, CLK_DEL); synchronous-reset shift register used
//    for the timing/rgb/in_win delay lines. Address and output stages stay in this module.
// TESTING
//  - Reset: rst=1 for 5 clks with active inputs -> all outputs 0; after release, outputs 0
//    for LATENCY=3 clks, then *_out equal *_in delayed by 3.
//  - Addressing: xpos=100, ypos=50 latched at vblnk; hcount=150, vcount=60 -> address
//    16'h0A32 one clk later. hcount=300 (outside) -> address 0 and rgb_out=rgb_in.
//  - Compositing: ROM model returns address[11:0]. Check rgb_out equals the model value
//    inside the 200x100 window, rgb_in outside, 0 when blanked.
//  - Frame latch: change xpos 100->400 at mid-frame line 300 -> rest of frame drawn at 100;
//    next frame drawn at 400.
//  - Clipping: xpos=1000, 1024-wide screen -> image columns 0..23 drawn at hcount 1000..1023;
//    nothing drawn at hcount 0..175 of the next line.
//  - Transparency: TRANSP_EN=1, ROM returns 12'hF0F at one pixel -> rgb_out=rgb_in there;
//    neighbouring pixels show the image.

Source files
------------

// File: rtl/vga_draw_image_pkg.sv
// Shared VGA stream definitions: count/colour/ROM address widths, blank colour and
// the timing+background bundle carried through the image pipeline.
package vga_draw_image_pkg;

   localparam int CNT_W  = 11;
   localparam int RGB_W  = 12;
   localparam int ADDR_W = 16;
   localparam logic [RGB_W-1:0] BLANK_RGB = 12'h000;

   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
      logic [RGB_W-1:0] rgb;
   } vga_bus_t;

endpackage

// File: rtl/vga_draw_image_signal_delay.sv
// Fixed-length shift register with synchronous reset; every stage clears on rst.
module signal_delay #(
   parameter int WIDTH   = 8,
   parameter int CLK_DEL = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [CLK_DEL-1:0][WIDTH-1:0] stage_p;

   always_ff @(posedge clk) begin
      if (rst) begin
         stage_p <= '0;
      end else begin
         stage_p[0] <= din;
         for (int i = 1; i < CLK_DEL; i++) begin
            stage_p[i] <= stage_p[i-1];
         end
      end
   end

   assign dout = stage_p[CLK_DEL-1];

endmodule

// File: rtl/vga_draw_image.sv
// Image-ROM reader: issues per-pixel ROM addresses for a window latched once per frame
// and overlays the returned pixel onto the background stream.
module vga_draw_image
   import vga_draw_image_pkg::*;
#(
   parameter int               IMG_WIDTH   = 200,
   parameter int               IMG_HEIGHT  = 100,
   parameter int               ROM_LATENCY = 1,
   parameter int               TRANSP_EN   = 0,
   parameter logic [RGB_W-1:0] TRANSP_RGB  = 12'hF0F
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [CNT_W-1:0]  hcount_in,
   input  logic [CNT_W-1:0]  vcount_in,
   input  logic              hsync_in,
   input  logic              vsync_in,
   input  logic              hblnk_in,
   input  logic              vblnk_in,
   input  logic [RGB_W-1:0]  rgb_in,
   input  logic [11:0]       xpos,
   input  logic [11:0]       ypos,
   output logic [ADDR_W-1:0] address,
   input  logic [RGB_W-1:0]  rgb_pixel,
   output logic [CNT_W-1:0]  hcount_out,
   output logic [CNT_W-1:0]  vcount_out,
   output logic              hsync_out,
   output logic              vsync_out,
   output logic              hblnk_out,
   output logic              vblnk_out,
   output logic [RGB_W-1:0]  rgb_out
);

   localparam int BUS_W = $bits(vga_bus_t);

   logic        vblnk_prev;
   logic [11:0] xpos_q;
   logic [11:0] ypos_q;

   // Position only moves on the first vblank clock so a frame is never torn.
   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_prev <= 1'b0;
         xpos_q     <= '0;
         ypos_q     <= '0;
      end else begin
         vblnk_prev <= vblnk_in;
         if (vblnk_in && !vblnk_prev) begin
            xpos_q <= xpos;
            ypos_q <= ypos;
         end
      end
   end

   // Stage p0: window test in 13 bits so positions near 4095 cannot wrap.
   logic [12:0] h_ext_p0, v_ext_p0, x_ext_p0, y_ext_p0;
   logic        in_win_p0;
   logic [7:0]  rel_x_p0, rel_y_p0;
   vga_bus_t    bus_p0;

   always_comb begin
      h_ext_p0  = {2'b00, hcount_in};
      v_ext_p0  = {2'b00, vcount_in};
      x_ext_p0  = {1'b0, xpos_q};
      y_ext_p0  = {1'b0, ypos_q};
      in_win_p0 = (h_ext_p0 >= x_ext_p0) && (h_ext_p0 < x_ext_p0 + 13'(IMG_WIDTH)) &&
                  (v_ext_p0 >= y_ext_p0) && (v_ext_p0 < y_ext_p0 + 13'(IMG_HEIGHT));
      rel_x_p0  = hcount_in[7:0] - xpos_q[7:0];
      rel_y_p0  = vcount_in[7:0] - ypos_q[7:0];
      bus_p0    = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                    vsync: vsync_in, hblnk: hblnk_in, vblnk: vblnk_in, rgb: rgb_in};
   end

   // Stage p1: ROM address register.
   always_ff @(posedge clk) begin
      if (rst) begin
         address <= '0;
      end else begin
         address <= in_win_p0 ? {rel_y_p0, rel_x_p0} : '0;
      end
   end

   // Stages p1..pd: timing, background and window flag wait for the ROM read.
   vga_bus_t bus_pd;
   logic     in_win_pd;

   signal_delay #(
      .WIDTH   (BUS_W + 1),
      .CLK_DEL (ROM_LATENCY + 1)
   ) u_delay (
      .clk  (clk),
      .rst  (rst),
      .din  ({bus_p0, in_win_p0}),
      .dout ({bus_pd, in_win_pd})
   );

   logic transp_pd;
   assign transp_pd = (TRANSP_EN != 0) && (rgb_pixel == TRANSP_RGB);

   // Output stage: blanking beats image, image beats background.
   always_ff @(posedge clk) begin
      if (rst) begin
         hcount_out <= '0;
         vcount_out <= '0;
         hsync_out  <= 1'b0;
         vsync_out  <= 1'b0;
         hblnk_out  <= 1'b0;
         vblnk_out  <= 1'b0;
         rgb_out    <= BLANK_RGB;
      end else begin
         hcount_out <= bus_pd.hcount;
         vcount_out <= bus_pd.vcount;
         hsync_out  <= bus_pd.hsync;
         vsync_out  <= bus_pd.vsync;
         hblnk_out  <= bus_pd.hblnk;
         vblnk_out  <= bus_pd.vblnk;
         if (bus_pd.hblnk || bus_pd.vblnk) begin
            rgb_out <= BLANK_RGB;
         end else if (in_win_pd && !transp_pd) begin
            rgb_out <= rgb_pixel;
         end else begin
            rgb_out <= bus_pd.rgb;
         end
      end
   end

endmodule

// File: tb/tb_vga_draw_image.sv
// Bench for vga_draw_image: two instances (opaque and colour-keyed) fed by the same
// stream, each with its own registered ROM, compared against a per-pixel reference.
module tb_vga_draw_image;
   import vga_draw_image_pkg::*;

   localparam int W = 200;
   localparam int H = 100;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst = 1'b1;
   logic [10:0] hcount_in = '0, vcount_in = '0;
   logic        hsync_in = 1'b0, vsync_in = 1'b0, hblnk_in = 1'b0, vblnk_in = 1'b0;
   logic [11:0] rgb_in = '0, xpos = '0, ypos = '0;

   logic [15:0] address1, address2;
   logic [11:0] rgb_pixel1, rgb_pixel2, rgb_out1, rgb_out2;
   logic [10:0] hcount_out1, vcount_out1, hcount_out2, vcount_out2;
   logic        hsync_out1, vsync_out1, hblnk_out1, vblnk_out1;
   logic        hsync_out2, vsync_out2, hblnk_out2, vblnk_out2;

   vga_draw_image dut1 (
      .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .address(address1), .rgb_pixel(rgb_pixel1),
      .hcount_out(hcount_out1), .vcount_out(vcount_out1), .hsync_out(hsync_out1),
      .vsync_out(vsync_out1), .hblnk_out(hblnk_out1), .vblnk_out(vblnk_out1),
      .rgb_out(rgb_out1));

   vga_draw_image #(.TRANSP_EN(1), .TRANSP_RGB(12'hF0F)) dut2 (
      .clk(clk), .rst(rst), .hcount_in(hcount_in), .vcount_in(vcount_in),
      .hsync_in(hsync_in), .vsync_in(vsync_in), .hblnk_in(hblnk_in), .vblnk_in(vblnk_in),
      .rgb_in(rgb_in), .xpos(xpos), .ypos(ypos), .address(address2), .rgb_pixel(rgb_pixel2),
      .hcount_out(hcount_out2), .vcount_out(vcount_out2), .hsync_out(hsync_out2),
      .vsync_out(vsync_out2), .hblnk_out(hblnk_out2), .vblnk_out(vblnk_out2),
      .rgb_out(rgb_out2));

   // Registered ROMs; the keyed one returns the colour key at image pixel (10,5).
   always_ff @(posedge clk) begin
      rgb_pixel1 <= address1[11:0];
      rgb_pixel2 <= (address2 == 16'h050A) ? 12'hF0F : address2[11:0];
   end

   typedef struct {
      bit          rst;
      logic [25:0] timing;
      logic [11:0] exp1;
      logic [11:0] exp2;
   } rec_t;

   rec_t hist[$];
   int   k = 0;
   int   mq_x = 0, mq_y = 0;
   bit   mprev = 0;
   int   vectors = 0, miscompares = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s edge=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   // One pixel clock: drive, predict from the frame-level rules, then check.
   task automatic step(input bit r, input int hc, input int vc,
                       input logic [11:0] xp, input logic [11:0] yp);
      rec_t        e;
      bit          win, blank, z;
      int          rx, ry;
      logic [11:0] rom1, rom2;
      logic [15:0] exp_addr;
      logic [25:0] exp_t;
      @(negedge clk);
      rst       = r;
      hcount_in = 11'(hc);
      vcount_in = 11'(vc);
      hblnk_in  = (hc >= 1024);
      vblnk_in  = (vc >= 768);
      hsync_in  = 1'($urandom_range(0, 1));
      vsync_in  = 1'($urandom_range(0, 1));
      rgb_in    = 12'($urandom);
      xpos      = xp;
      ypos      = yp;

      win   = (hc >= mq_x) && (hc < mq_x + W) && (vc >= mq_y) && (vc < mq_y + H);
      blank = hblnk_in || vblnk_in;
      rx    = (hc - mq_x) & 255;
      ry    = (vc - mq_y) & 255;
      rom1  = 12'(((ry & 15) << 8) | rx);
      rom2  = (rx == 10 && ry == 5) ? 12'hF0F : rom1;
      e.rst    = r;
      e.timing = {hcount_in, vcount_in, hsync_in, vsync_in, hblnk_in, vblnk_in};
      e.exp1   = blank ? 12'h000 : (win ? rom1 : rgb_in);
      e.exp2   = blank ? 12'h000 : ((win && rom2 != 12'hF0F) ? rom2 : rgb_in);
      exp_addr = (!r && win) ? 16'((ry << 8) | rx) : 16'h0000;
      hist.push_back(e);

      if (r) begin
         mq_x  = 0;
         mq_y  = 0;
         mprev = 0;
      end else begin
         if (vblnk_in && !mprev) begin
            mq_x = int'(xp);
            mq_y = int'(yp);
         end
         mprev = vblnk_in;
      end

      @(posedge clk);
      #1;
      chk("address", 32'(address1), 32'(exp_addr));
      chk("address_keyed", 32'(address2), 32'(exp_addr));
      z = (k < 2) || hist[k].rst || hist[k-1].rst || hist[k-2].rst;
      exp_t = z ? 26'h0 : hist[k-2].timing;
      chk("timing", 32'({hcount_out1, vcount_out1, hsync_out1, vsync_out1, hblnk_out1, vblnk_out1}),
          32'(exp_t));
      chk("timing_keyed", 32'({hcount_out2, vcount_out2, hsync_out2, vsync_out2, hblnk_out2, vblnk_out2}),
          32'(exp_t));
      chk("rgb_out", 32'(rgb_out1), z ? 32'h0 : 32'(hist[k-2].exp1));
      chk("rgb_out_keyed", 32'(rgb_out2), z ? 32'h0 : 32'(hist[k-2].exp2));
      k++;
   endtask

   task automatic seg(input int vc, input int h0, input int h1,
                      input logic [11:0] xp, input logic [11:0] yp);
      for (int h = h0; h <= h1; h++) step(1'b0, h, vc, xp, yp);
   endtask

   task automatic vbl(input logic [11:0] xp, input logic [11:0] yp);
      for (int i = 0; i < 3; i++) step(1'b0, 0, 770 + i, xp, yp);
   endtask

   initial begin
      // reset with an active stream
      for (int i = 0; i < 5; i++)
         step(1'b1, $urandom_range(0, 1023), $urandom_range(0, 767), 12'($urandom), 12'($urandom));
      seg(10, 0, 20, 12'd700, 12'd700);

      // frame at (100,50): address, window edges, key pixels, blanking
      vbl(12'd100, 12'd50);
      seg(60, 140, 160, 12'($urandom), 12'($urandom));
      seg(60, 290, 310, 12'($urandom), 12'($urandom));
      seg(49, 95, 105, 12'($urandom), 12'($urandom));
      seg(50, 95, 105, 12'($urandom), 12'($urandom));
      seg(149, 295, 305, 12'($urandom), 12'($urandom));
      seg(150, 295, 305, 12'($urandom), 12'($urandom));
      seg(55, 105, 115, 12'($urandom), 12'($urandom));
      seg(65, 110, 120, 12'($urandom), 12'($urandom));
      seg(60, 1018, 1030, 12'($urandom), 12'($urandom));
      for (int i = 0; i < 200; i++)
         step(1'b0, 80 + $urandom_range(0, 240), 40 + $urandom_range(0, 120),
              12'($urandom), 12'($urandom));

      // mid-frame position change takes effect only next frame
      vbl(12'd100, 12'd250);
      seg(300, 90, 110, 12'd100, 12'd250);
      seg(300, 390, 410, 12'd400, 12'd250);
      seg(310, 90, 110, 12'd400, 12'd250);
      seg(310, 390, 410, 12'd400, 12'd250);
      vbl(12'd400, 12'd250);
      seg(310, 90, 110, 12'd400, 12'd250);
      seg(310, 390, 410, 12'd400, 12'd250);

      // right-edge clipping, no wrap onto the next line
      vbl(12'd1000, 12'd0);
      seg(5, 990, 1030, 12'd1000, 12'd0);
      seg(6, 0, 180, 12'd1000, 12'd0);

      // positions near the top of the 12-bit range
      vbl(12'd4000, 12'd0);
      seg(5, 0, 210, 12'd4000, 12'd0);
      vbl(12'hFFF, 12'hFFF);
      seg(0, 0, 10, 12'hFFF, 12'hFFF);

      // vblank priority over an image that extends into the blanking region
      vbl(12'd150, 12'd700);
      seg(710, 145, 160, 12'd150, 12'd700);
      seg(770, 145, 160, 12'd150, 12'd700);

      // mid-frame reset falls back to position 0,0
      vbl(12'd300, 12'd300);
      seg(310, 295, 305, 12'd300, 12'd300);
      step(1'b1, 306, 310, 12'd300, 12'd300);
      step(1'b1, 307, 310, 12'd300, 12'd300);
      seg(5, 0, 12, 12'($urandom), 12'($urandom));
      seg(310, 298, 306, 12'($urandom), 12'($urandom));
      vbl(12'd20, 12'd30);
      seg(40, 10, 30, 12'($urandom), 12'($urandom));
      seg(400, 0, 3, 12'($urandom), 12'($urandom));

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
